pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage MIPS core. It combines stall requests from ID, EX and MEM into per-stage stall vectors that drive the pc, if_id, id_ex, ex_mem and mem_wb registers. It sequences exception and ERET redirects as a two-cycle freeze-then-flush operation. It also maintains stall statistics and a stall watchdog.

---
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage MIPS core: merges stage stall requests,
// sequences exception/ERET redirects as freeze-then-flush, and tracks stall statistics.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic        timeout
);

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_FREEZE   = 2'd1;
    localparam logic [1:0]  ST_FLUSH    = 2'd2;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    localparam logic [5:0]  STALL_MEM   = 6'b011111;
    localparam logic [5:0]  STALL_EX    = 6'b001111;
    localparam logic [5:0]  STALL_ID    = 6'b000111;

    logic [1:0]  r_state;
    logic [31:0] r_target;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_run_cnt;
    logic        r_timeout;

    logic [5:0]  w_stall;
    logic        w_accept;
    logic        w_flush;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        w_stall  = 6'b000000;
        w_accept = 1'b0;
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    if (stallreq_mem)     w_stall = STALL_MEM;
                    else if (stallreq_ex) w_stall = STALL_EX;
                    else if (stallreq_id) w_stall = STALL_ID;
                    // A redirect waits until MEM has finished its access.
                    w_accept = (exc_valid | eret_valid) & ~stallreq_mem;
                end
                ST_FREEZE: w_stall = STALL_MEM;
                default:   w_stall = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            r_state     <= ST_RUN;
            r_target    <= 32'd0;
            r_stall_cnt <= 32'd0;
            r_run_cnt   <= 16'd0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_target <= exc_valid ? EXC_VECTOR : epc;
                        r_state  <= ST_FREEZE;
                    end
                end
                ST_FREEZE: r_state <= ST_FLUSH;
                default:   r_state <= ST_RUN;
            endcase

            if (w_stall != 6'b000000) begin
                if (r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
                if (r_run_cnt != TIMEOUT_LIM) begin
                    r_run_cnt <= r_run_cnt + 16'd1;
                    if (r_run_cnt + 16'd1 == TIMEOUT_LIM) r_timeout <= 1'b1;
                end
            end else begin
                r_run_cnt <= 16'd0;
            end
        end
    end

    assign w_flush   = (r_state == ST_FLUSH);
    assign stall     = w_stall;
    assign flush     = w_flush;
    assign new_pc    = w_flush ? r_target : 32'd0;
    assign stall_cnt = r_stall_cnt;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-schedule model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam int          TO_LIM  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_valid, eret_valid;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cnt;
    logic        timeout;

    int n_total = 0;
    int n_bad   = 0;

    pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .TIMEOUT_CYCLES(TO_LIM)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: redirects are recorded as absolute cycle numbers of their freeze and flush.
    bit          m_valid = 1'b0;
    int          m_cyc = 0;
    int          m_freeze_at = -10;
    int          m_flush_at = -10;
    logic [31:0] m_tgt = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    int          m_run = 0;
    bit          m_to = 1'b0;

    function automatic logic [5:0] exp_stall();
        if (!rst)                 return 6'b000000;
        if (m_cyc == m_flush_at)  return 6'b000000;
        if (m_cyc == m_freeze_at) return 6'b011111;
        if (stallreq_mem)         return 6'b011111;
        if (stallreq_ex)          return 6'b001111;
        if (stallreq_id)          return 6'b000111;
        return 6'b000000;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_valid     <= 1'b1;
            m_freeze_at <= -10;
            m_flush_at  <= -10;
            m_tgt       <= 32'd0;
            m_cnt       <= 32'd0;
            m_run       <= 0;
            m_to        <= 1'b0;
        end else if (m_valid) begin
            if (exp_stall() != 6'b000000) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
                if (m_run < TO_LIM) m_run <= m_run + 1;
                if (m_run + 1 >= TO_LIM) m_to <= 1'b1;
            end else begin
                m_run <= 0;
            end
            if (m_cyc != m_freeze_at && m_cyc != m_flush_at &&
                (exc_valid || eret_valid) && !stallreq_mem) begin
                m_tgt       <= exc_valid ? EXC_VEC : epc;
                m_freeze_at <= m_cyc + 1;
                m_flush_at  <= m_cyc + 2;
            end
        end
        m_cyc <= m_cyc + 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_stall", {26'd0, stall}, {26'd0, exp_stall()});
            check("model_flush", {31'd0, flush}, {31'd0, m_cyc == m_flush_at});
            check("model_new_pc", new_pc, (m_cyc == m_flush_at) ? m_tgt : 32'd0);
            check("model_stall_cnt", stall_cnt, m_cnt);
            check("model_timeout", {31'd0, timeout}, {31'd0, m_to});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_valid = 0; eret_valid = 0; epc = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        // Reset wins over stall and exception requests.
        stallreq_mem = 1; exc_valid = 1;
        step(); step();
        check("rst_stall", {26'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_new_pc", new_pc, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b1; idle_inputs();
        step();
        check("post_rst_stall", {26'd0, stall}, 32'd0);

        // Stall priority and counting.
        stallreq_id = 1; settle();
        check("stall_id", {26'd0, stall}, 32'h07);
        step(); step(); step();
        stallreq_ex = 1; settle();
        check("stall_ex", {26'd0, stall}, 32'h0F);
        step(); step(); step();
        stallreq_mem = 1; settle();
        check("stall_mem", {26'd0, stall}, 32'h1F);
        step(); step(); step();
        idle_inputs(); settle();
        check("stall_release", {26'd0, stall}, 32'd0);
        check("stall_cnt_9", stall_cnt, 32'd9);
        check("long_stall_timeout", {31'd0, timeout}, 32'd1);
        do_reset();

        // Exception redirect.
        exc_valid = 1;
        step();
        exc_valid = 0; settle();
        check("exc_freeze_stall", {26'd0, stall}, 32'h1F);
        check("exc_freeze_flush", {31'd0, flush}, 32'd0);
        step();
        check("exc_flush", {31'd0, flush}, 32'd1);
        check("exc_new_pc", new_pc, 32'hBFC00380);
        check("exc_flush_stall", {26'd0, stall}, 32'd0);
        step();
        check("exc_after_flush", {31'd0, flush}, 32'd0);
        check("exc_after_new_pc", new_pc, 32'd0);

        // ERET redirect.
        eret_valid = 1; epc = 32'h80001234;
        step();
        eret_valid = 0;
        step();
        check("eret_flush", {31'd0, flush}, 32'd1);
        check("eret_new_pc", new_pc, 32'h80001234);
        step();

        // Exception beats ERET; requests during FREEZE/FLUSH are ignored.
        exc_valid = 1; eret_valid = 1; epc = 32'h00000444;
        step();
        eret_valid = 0;
        step();
        check("both_new_pc", new_pc, 32'hBFC00380);
        step();
        exc_valid = 0; settle();
        check("no_second_flush_a", {31'd0, flush}, 32'd0);
        step();
        check("no_second_flush_b", {31'd0, flush}, 32'd0);

        // Deferred accept behind a MEM wait.
        stallreq_mem = 1; exc_valid = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("defer_flush", {31'd0, flush}, 32'd0);
            check("defer_stall", {26'd0, stall}, 32'h1F);
        end
        stallreq_mem = 0; settle();
        check("defer_accept_stall", {26'd0, stall}, 32'd0);
        step();
        exc_valid = 0; settle();
        check("defer_freeze", {26'd0, stall}, 32'h1F);
        check("defer_freeze_flush", {31'd0, flush}, 32'd0);
        step();
        check("defer_flush_hit", {31'd0, flush}, 32'd1);
        check("defer_new_pc", new_pc, 32'hBFC00380);
        step();

        // Watchdog.
        do_reset();
        stallreq_ex = 1;
        step(); step(); step();
        stallreq_ex = 0;
        step();
        check("wd_3_cycles", {31'd0, timeout}, 32'd0);
        stallreq_ex = 1;
        step(); step(); step();
        check("wd_before_4", {31'd0, timeout}, 32'd0);
        step();
        check("wd_4_cycles", {31'd0, timeout}, 32'd1);
        stallreq_ex = 0;
        step(); step();
        check("wd_sticky", {31'd0, timeout}, 32'd1);

        // Reset during FLUSH.
        exc_valid = 1;
        step();
        exc_valid = 0;
        step();
        check("midrst_flush_before", {31'd0, flush}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_timeout", {31'd0, timeout}, 32'd0);
        check("midrst_stall_cnt", stall_cnt, 32'd0);
        step(); step();
        check("midrst_no_flush", {31'd0, flush}, 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
